crypto_exec: RTL and testbench



---
 rtl/crypto_exec.sv | 133 +++++++++++++
 tb/tb_crypto_exec.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/crypto_exec.sv
// Execute stage of the crypto coprocessor: single-cycle ARX / SHA-2 ops plus a
// 32-step shift-add multiply, driving the register-file write port directly.
module crypto_exec #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        write_enable,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        illegal_op,
  output logic        busy
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_XOR   = 4'd1;
  localparam logic [3:0] OP_ROTL  = 4'd2;
  localparam logic [3:0] OP_ROTR  = 4'd3;
  localparam logic [3:0] OP_CH    = 4'd4;
  localparam logic [3:0] OP_MAJ   = 4'd5;
  localparam logic [3:0] OP_ADD3  = 4'd6;
  localparam logic [3:0] OP_MULLO = 4'd7;

  // The write-back ("done") happens on the same edge as the last iteration,
  // so completion is a transition out of MUL rather than a state of its own.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [5:0] LAST_ITER = 6'(MUL_CYCLES - 1);

  logic [0:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplr;
  logic [4:0]  r_rd;

  logic        w_accept;
  logic [5:0]  w_rot_inv;
  logic [31:0] w_rotl;
  logic [31:0] w_rotr;
  logic [31:0] w_alu;
  logic [31:0] w_acc_next;

  assign in_ready = (r_state == ST_IDLE) && !rst;
  assign busy     = (r_state == ST_MUL);
  assign w_accept = in_valid && in_ready;

  // A shift by 32 yields zero, so shamt=0 collapses to a plain pass-through.
  assign w_rot_inv = 6'd32 - {1'b0, shamt};
  assign w_rotl    = (a << shamt) | (a >> w_rot_inv);
  assign w_rotr    = (a >> shamt) | (a << w_rot_inv);

  assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : 32'd0);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_alu
    // unassigned, which would otherwise infer a latch.
    w_alu = '0;
    case (op)
      OP_ADD:  w_alu = a + b;
      OP_XOR:  w_alu = a ^ b;
      OP_ROTL: w_alu = w_rotl;
      OP_ROTR: w_alu = w_rotr;
      OP_CH:   w_alu = (a & b) ^ (~a & c);
      OP_MAJ:  w_alu = (a & b) ^ (a & c) ^ (b & c);
      OP_ADD3: w_alu = a + b + c;
      default: w_alu = '0;
    endcase
  end

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mplr       <= '0;
      r_rd         <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      illegal_op   <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      illegal_op   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (op == OP_MULLO) begin
              r_state <= ST_MUL;
              r_mcand <= a;
              r_mplr  <= b;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_rd    <= rd;
            end else if (op[3]) begin
              illegal_op <= 1'b1;
            end else begin
              write_enable <= 1'b1;
              write_addr   <= rd;
              write_data   <= w_alu;
            end
          end
        end
        ST_MUL: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + 6'd1;
          if (r_cnt == LAST_ITER) begin
            r_state      <= ST_IDLE;
            write_enable <= 1'b1;
            write_addr   <= r_rd;
            write_data   <= w_acc_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_exec.sv
// Scoreboard bench for crypto_exec: stimulus pushes expected write-port
// activity, a negedge monitor pops and compares whatever the DUT presents.
module tb_crypto_exec;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        illegal_op;
  logic        busy;

  typedef struct {
    logic        we;
    logic        ill;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  crypto_exec #(.MUL_CYCLES(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .rd           (rd),
    .shamt        (shamt),
    .a            (a),
    .b            (b),
    .c            (c),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .illegal_op   (illegal_op),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write or illegal pulse must match the oldest pending entry.
  always @(negedge clk) begin
    if (!rst && (write_enable || illegal_op)) begin
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_we", 32'(write_enable), 32'(e.we));
        check("sb_illegal", 32'(illegal_op), 32'(e.ill));
        if (e.we) begin
          check("sb_addr", 32'(write_addr), 32'(e.addr));
          check("sb_data", write_data, e.data);
        end
      end
    end
  end

  // Present an instruction, wait (bounded) for ready, transfer on the next edge.
  task automatic issue(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s,
                       input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc,
                       input bit push, input logic [4:0] ea, input logic [31:0] ed,
                       input bit eill);
    int n;
    exp_t e;
    in_valid = 1'b1;
    op = o; rd = d; shamt = s; a = va; b = vb; c = vc;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    if (push) begin
      e.we = !eill; e.ill = eill; e.addr = ea; e.data = ed;
      sb_q.push_back(e);
    end
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0;
    op = '0; rd = '0; shamt = '0; a = '0; b = '0; c = '0;
    @(negedge clk);
    check("ready_in_reset", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_addr", 32'(write_addr), 32'd0);
    check("rst_data", write_data, 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // Back-to-back single-cycle ops; shamt on ADD must be ignored.
    issue(4'd0, 5'd15, 5'd7, 32'hFFFFFFFF, 32'h2, 32'h0, 1, 5'd15, 32'h00000001, 0);
    issue(4'd1, 5'd0, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1, 5'd0, 32'h0FF00FF0, 0);
    issue(4'd3, 5'd1, 5'd1, 32'h00000001, 32'h0, 32'h0, 1, 5'd1, 32'h80000000, 0);
    issue(4'd2, 5'd2, 5'd4, 32'h80000001, 32'h0, 32'h0, 1, 5'd2, 32'h00000018, 0);
    issue(4'd2, 5'd3, 5'd0, 32'hCAFEF00D, 32'h0, 32'h0, 1, 5'd3, 32'hCAFEF00D, 0);
    issue(4'd4, 5'd4, 5'd0, 32'hFF00FF00, 32'h12345678, 32'h9ABCDEF0, 1, 5'd4, 32'h12BC56F0, 0);
    // MAJ: bytes where a=FF give b|c, bytes where a=00 give b&c.
    issue(4'd5, 5'd5, 5'd0, 32'hFF00FF00, 32'h12345678, 32'h9ABCDEF0, 1, 5'd5, 32'h9A34DE70, 0);
    issue(4'd6, 5'd6, 5'd0, 32'h1, 32'h2, 32'hFFFFFFFE, 1, 5'd6, 32'h00000001, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 check("we_drops", 32'(write_enable), 32'd0);
    check("addr_holds", 32'(write_addr), 32'd6);

    // Multiply: 32-cycle stall, operands changed after accept must not matter.
    issue(4'd7, 5'd7, 5'd0, 32'h00010001, 32'h00010001, 32'h0, 1, 5'd7, 32'h00020001, 0);
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h0;
    @(negedge clk);
    check("mul_busy", 32'(busy), 32'd1);
    n = 0;
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("mul_stall_cycles", 32'(n), 32'd32);
    check("mul_busy_clear", 32'(busy), 32'd0);
    // Next accept straight after the multiply.
    issue(4'd0, 5'd8, 5'd0, 32'h10, 32'h20, 32'h0, 1, 5'd8, 32'h30, 0);
    in_valid = 1'b0;
    @(posedge clk);

    // Multiply aborted by reset in its 10th cycle: no write may ever appear.
    issue(4'd7, 5'd9, 5'd0, 32'h3, 32'h5, 32'h0, 0, 5'd0, 32'h0, 0);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_ready_in_rst", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(write_enable), 32'd0);
    @(negedge clk);
    check("abort_ready", 32'(in_ready), 32'd1);
    repeat (40) @(negedge clk);

    // Illegal op pulses without a write; the following ADD still lands.
    issue(4'd12, 5'd10, 5'd0, 32'h1, 32'h1, 32'h0, 1, 5'd0, 32'h0, 1);
    issue(4'd0, 5'd11, 5'd0, 32'h7, 32'h8, 32'h0, 1, 5'd11, 32'h0000000F, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 check("illegal_clear", 32'(illegal_op), 32'd0);
    repeat (3) @(posedge clk);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
